// File: rtl/line_buffer_5row.sv
// 5-row vertical window generator: four line memories plus the live line, 2-clock latency.
// Optional BORDER_REPLICATE_EN: invalid rows replicate the oldest valid row instead of 0.
module line_buffer_5row #(
   parameter int DATA_W    = 8,
   parameter int MAX_WIDTH = 2048,
   parameter int COL_W     = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] pixel_i,
   input  logic              dv_i,
   input  logic              hs_i,
   input  logic              vs_i,
   output logic [DATA_W-1:0] pixel0,
   output logic [DATA_W-1:0] pixel1,
   output logic [DATA_W-1:0] pixel2,
   output logic [DATA_W-1:0] pixel3,
   output logic [DATA_W-1:0] pixel4,
   output logic              dv_o,
   output logic              hs_o,
   output logic              vs_o
);

   // One extra bit so the column can saturate at MAX_WIDTH itself.
   localparam int CW = COL_W + 1;
   localparam logic [CW-1:0] MAX_COL = CW'(MAX_WIDTH);

   logic [DATA_W-1:0] mem [4][MAX_WIDTH];
   logic [DATA_W-1:0] rd [4];
   logic [DATA_W-1:0] row [1:4];
   logic [DATA_W-1:0] fill;

   logic [CW-1:0]     col;
   logic [COL_W-1:0]  addr;
   logic [1:0]        wr_ptr;
   logic [2:0]        valid_lines;
   logic              dv_q;
   logic              vs_q;
   logic              in_range;
   logic              sof;
   logic              eol;
   logic              we;

   logic [DATA_W-1:0] pix_d1;
   logic              dv_d1;
   logic              hs_d1;
   logic              vs_d1;
   logic              ovf_d1;
   logic [1:0]        wp_d1;
   logic [2:0]        vl_d1;

   assign in_range = col < MAX_COL;
   assign addr     = col[COL_W-1:0];
   assign sof      = vs_i & ~vs_q;
   assign eol      = dv_q & ~dv_i;
   assign we       = dv_i & in_range;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col         <= '0;
         wr_ptr      <= '0;
         valid_lines <= '0;
         dv_q        <= 1'b0;
         vs_q        <= 1'b0;
      end else begin
         dv_q <= dv_i;
         vs_q <= vs_i;
         if (sof) begin
            col         <= '0;
            wr_ptr      <= '0;
            valid_lines <= '0;
         end else begin
            if (dv_i) begin
               if (in_range) col <= col + CW'(1);
            end else if (dv_q) begin
               col <= '0;
            end
            if (eol) begin
               wr_ptr <= wr_ptr + 2'd1;
               if (valid_lines != 3'd4) valid_lines <= valid_lines + 3'd1;
            end
         end
      end
   end

   // Non-blocking read and write of the same RAM give the 4-lines-old value.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int j = 0; j < 4; j++) rd[j] <= mem[j][addr];
         mem[wr_ptr][addr] <= pixel_i;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pix_d1 <= '0;
         dv_d1  <= 1'b0;
         hs_d1  <= 1'b0;
         vs_d1  <= 1'b0;
         ovf_d1 <= 1'b0;
         wp_d1  <= '0;
         vl_d1  <= '0;
      end else begin
         pix_d1 <= pixel_i;
         dv_d1  <= dv_i;
         hs_d1  <= hs_i;
         vs_d1  <= vs_i;
         ovf_d1 <= ~in_range;
         wp_d1  <= wr_ptr;
         vl_d1  <= valid_lines;
      end
   end

   always_comb begin
`ifdef BORDER_REPLICATE_EN
      fill = (vl_d1 == 3'd0) ? pix_d1 : rd[wp_d1 - vl_d1[1:0]];
`else
      fill = '0;
`endif
      for (int k = 1; k <= 4; k++) begin
         row[k] = '0;
         if (!ovf_d1) begin
            if (vl_d1 >= 3'(k)) row[k] = rd[wp_d1 - 2'(k)];
            else                row[k] = fill;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pixel0 <= '0;
         pixel1 <= '0;
         pixel2 <= '0;
         pixel3 <= '0;
         pixel4 <= '0;
         dv_o   <= 1'b0;
         hs_o   <= 1'b0;
         vs_o   <= 1'b0;
      end else begin
         dv_o <= dv_d1;
         hs_o <= hs_d1;
         vs_o <= vs_d1;
         if (dv_d1) begin
            pixel4 <= pix_d1;
            pixel3 <= row[1];
            pixel2 <= row[2];
            pixel1 <= row[3];
            pixel0 <= row[4];
         end
      end
   end

endmodule

// File: tb/tb_line_buffer_5row.sv
// Directed bench for line_buffer_5row (small MAX_WIDTH so the overflow line stays short).
// Expected rows follow BORDER_REPLICATE_EN when it is defined for the build.
module tb_line_buffer_5row;

   typedef struct packed {
      logic [7:0] p4;
      logic [7:0] p3;
      logic [7:0] p2;
      logic [7:0] p1;
      logic [7:0] p0;
      logic       dv;
      logic       hs;
      logic       vs;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] pixel_i = '0;
   logic       dv_i = 1'b0;
   logic       hs_i = 1'b0;
   logic       vs_i = 1'b0;
   logic [7:0] pixel0, pixel1, pixel2, pixel3, pixel4;
   logic       dv_o, hs_o, vs_o;

   int   n_assert = 0;
   int   n_fail = 0;
   int   cyc = 0;
   obs_t out_h [2048];
   logic [2:0] in_h [2048];
   bit   rep;

   line_buffer_5row #(.DATA_W(8), .MAX_WIDTH(16), .COL_W(4)) dut (
      .clk(clk), .rst(rst), .pixel_i(pixel_i),
      .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
      .pixel0(pixel0), .pixel1(pixel1), .pixel2(pixel2),
      .pixel3(pixel3), .pixel4(pixel4),
      .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o)
   );

   always #5 clk = ~clk;

   // Outputs captured at step n reflect the inputs driven at step n-2.
   task automatic step(input logic [7:0] p, input logic d, input logic h, input logic v);
      @(posedge clk);
      #1;
      cyc++;
      out_h[cyc] = '{pixel4, pixel3, pixel2, pixel1, pixel0, dv_o, hs_o, vs_o};
      pixel_i = p;
      dv_i = d;
      hs_i = h;
      vs_i = v;
      in_h[cyc] = {d, h, v};
   endtask

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_col(input string tag, input int s, input int c,
                          input logic [7:0] e4, input logic [7:0] e3,
                          input logic [7:0] e2, input logic [7:0] e1,
                          input logic [7:0] e0);
      obs_t o;
      o = out_h[s + c + 2];
      chk({tag, ".dv"}, 8'(o.dv), 8'h01);
      chk({tag, ".p4"}, o.p4, e4);
      chk({tag, ".p3"}, o.p3, e3);
      chk({tag, ".p2"}, o.p2, e2);
      chk({tag, ".p1"}, o.p1, e1);
      chk({tag, ".p0"}, o.p0, e0);
   endtask

   task automatic chk_zero(input string tag);
      obs_t o;
      o = out_h[cyc];
      chk({tag, ".pix"}, 8'(o.p4 | o.p3 | o.p2 | o.p1 | o.p0), 8'h00);
      chk({tag, ".dv"}, 8'(o.dv), 8'h00);
   endtask

   task automatic send_line(input logic [7:0] base, input int n, output int s);
      s = 0;
      for (int c = 0; c < n; c++) begin
         step(base + 8'(c), 1'b1, 1'b0, 1'b0);
         if (c == 0) s = cyc;
      end
      step(8'h00, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic frame_start();
      step(8'h00, 1'b0, 1'b0, 1'b1);
      step(8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   function automatic logic [7:0] r(input logic [7:0] v);
      return rep ? v : 8'h00;
   endfunction

   initial begin
      int s [6];
      int sa, sb, sd, g;
      obs_t o;
`ifdef BORDER_REPLICATE_EN
      rep = 1'b1;
`else
      rep = 1'b0;
`endif
      for (int i = 0; i < 6; i++) begin
         step(8'(i * 37 + 1), i[0], i[1], i[2]);
         o = out_h[cyc];
         chk("rst.pix", 8'(o.p4 | o.p3 | o.p2 | o.p1 | o.p0), 8'h00);
         chk("rst.sync", 8'({o.dv, o.hs, o.vs}), 8'h00);
      end
      step(8'h00, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(8'(i + 9), 1'b0, 1'b0, 1'b0);
         chk_zero("post_rst");
      end

      frame_start();
      for (int l = 0; l < 6; l++) send_line(8'(16 * l), 8, s[l]);
      repeat (3) step(8'h00, 1'b0, 1'b0, 1'b0);

      chk_col("l0c5", s[0], 5, 8'h05, r(8'h05), r(8'h05), r(8'h05), r(8'h05));
      chk_col("l1c2", s[1], 2, 8'h12, 8'h02, r(8'h02), r(8'h02), r(8'h02));
      chk_col("l2c4", s[2], 4, 8'h24, 8'h14, 8'h04, r(8'h04), r(8'h04));
      chk_col("l4c7", s[4], 7, 8'h47, 8'h37, 8'h27, 8'h17, 8'h07);
      chk_col("l5c3", s[5], 3, 8'h53, 8'h43, 8'h33, 8'h23, 8'h13);
      chk_col("l5c0", s[5], 0, 8'h50, 8'h40, 8'h30, 8'h20, 8'h10);
      g = s[5] + 8;
      o = out_h[g + 2];
      chk("hold.dv", 8'(o.dv), 8'h00);
      chk("hold.p4", o.p4, 8'h57);
      chk("hold.p3", o.p3, 8'h47);

      frame_start();
      for (int l = 0; l < 3; l++) send_line(8'(16 * l + 1), 8, s[l]);
      frame_start();
      send_line(8'hA0, 8, sa);
      send_line(8'hB0, 20, sb);
      send_line(8'hD0, 8, sd);
      repeat (3) step(8'h00, 1'b0, 1'b0, 1'b0);

      chk_col("sof.c1", sa, 1, 8'hA1, r(8'hA1), r(8'hA1), r(8'hA1), r(8'hA1));
      chk_col("sof.c6", sa, 6, 8'hA6, r(8'hA6), r(8'hA6), r(8'hA6), r(8'hA6));
      chk_col("ovf.c2", sb, 2, 8'hB2, 8'hA2, r(8'hA2), r(8'hA2), r(8'hA2));
      for (int c = 16; c < 20; c++)
         chk_col("ovf.tail", sb, c, 8'hB0 + 8'(c), 8'h00, 8'h00, 8'h00, 8'h00);
      chk_col("next.c0", sd, 0, 8'hD0, 8'hB0, 8'hA0, r(8'hA0), r(8'hA0));
      chk_col("next.c3", sd, 3, 8'hD3, 8'hB3, 8'hA3, r(8'hA3), r(8'hA3));

      for (int i = 0; i < 100; i++) begin
         step(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         o = out_h[cyc];
         chk("sync.dv", 8'(o.dv), 8'(in_h[cyc - 2][2]));
         chk("sync.hs", 8'(o.hs), 8'(in_h[cyc - 2][1]));
         chk("sync.vs", 8'(o.vs), 8'(in_h[cyc - 2][0]));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
